gameover_renderer: RTL and testbench

Upstream feeder of the game-over palette lookup. Maps VGA beam coordinates onto a 160x120 game-over image stored in a 4-bit-index synchronous ROM, scaled 4x onto the 640x480 display. Runs a top-down reveal animation that advances once per frame. Outputs a pipelined palette index with a valid flag, ready for the palette and the downstream colour mux.

---
 rtl/gameover_pkg.sv | 32 +++
 rtl/gameover_renderer_if.sv | 30 +++
 rtl/gameover_addr_gen.sv | 34 +++
 rtl/gameover_renderer.sv | 113 +++++++++++
 tb/tb_gameover_renderer.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/gameover_pkg.sv
// gameover_pkg
// Shared constants, state type and helpers for the game-over image path
// (renderer, address generator, and the palette/ROM top that wraps them).
package gameover_pkg;

  localparam int IMG_W       = 160;  // image width in image pixels
  localparam int IMG_H       = 120;  // image height in image pixels
  localparam int SCALE_SH    = 2;    // log2 of display-to-image scale
  localparam int ADDR_W      = 15;   // ROM address width
  localparam int REVEAL_STEP = 4;    // image rows revealed per frame
  localparam int COORD_W     = 10;   // beam coordinate width
  localparam int IDX_W       = 4;    // palette index width
  localparam int IMG_CW      = COORD_W - SCALE_SH;  // scaled coordinate width

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REVEAL = 2'd1,
    HOLD   = 2'd2
  } go_state_t;

  // Next reveal line, saturating at the image height.
  function automatic logic [IMG_CW-1:0] next_reveal(input logic [IMG_CW-1:0] line);
    logic [IMG_CW:0] sum;
    sum = {1'b0, line} + (IMG_CW+1)'(REVEAL_STEP);
    if (sum >= (IMG_CW+1)'(IMG_H)) begin
      return IMG_CW'(IMG_H);
    end else begin
      return sum[IMG_CW-1:0];
    end
  endfunction

endpackage

// File: rtl/gameover_renderer_if.sv
// gameover_renderer_if
// Beam/control inputs, ROM port and pixel outputs of the game-over renderer.
//   master : beam timing + control source and image ROM (drives inputs, rom_data)
//   slave  : the renderer (drives rom_addr, pix_index, pix_valid, reveal_done)
interface gameover_renderer_if;
  import gameover_pkg::*;

  logic [COORD_W-1:0] draw_x;
  logic [COORD_W-1:0] draw_y;
  logic               de;
  logic               frame_start;
  logic               start;
  logic               clear;
  logic [ADDR_W-1:0]  rom_addr;
  logic [IDX_W-1:0]   rom_data;
  logic [IDX_W-1:0]   pix_index;
  logic               pix_valid;
  logic               reveal_done;

  modport master (
    output draw_x, draw_y, de, frame_start, start, clear, rom_data,
    input  rom_addr, pix_index, pix_valid, reveal_done
  );

  modport slave (
    input  draw_x, draw_y, de, frame_start, start, clear, rom_data,
    output rom_addr, pix_index, pix_valid, reveal_done
  );

endinterface

// File: rtl/gameover_addr_gen.sv
// gameover_addr_gen
// Combinational mapping of beam coordinates onto the 160x120 image.
//   draw_x_i, draw_y_i : beam column/row
//   de_i               : display enable
//   iy_o               : scaled image row
//   in_img_o           : beam is inside the image window during active video
//   addr_o             : row-major ROM address, zero outside the window
module gameover_addr_gen
  import gameover_pkg::*;
(
  input  logic [COORD_W-1:0] draw_x_i,
  input  logic [COORD_W-1:0] draw_y_i,
  input  logic               de_i,
  output logic [IMG_CW-1:0]  iy_o,
  output logic               in_img_o,
  output logic [ADDR_W-1:0]  addr_o
);

  logic [IMG_CW-1:0] ix_s;

  assign ix_s     = draw_x_i[COORD_W-1:SCALE_SH];
  assign iy_o     = draw_y_i[COORD_W-1:SCALE_SH];
  assign in_img_o = de_i && (ix_s < IMG_CW'(IMG_W)) && (iy_o < IMG_CW'(IMG_H));

  // Address arithmetic is done at full ADDR_W width so the product never truncates.
  always_comb begin
    if (in_img_o) begin
      addr_o = ADDR_W'(iy_o) * ADDR_W'(IMG_W) + ADDR_W'(ix_s);
    end else begin
      addr_o = {ADDR_W{1'b0}};
    end
  end

endmodule

// File: rtl/gameover_renderer.sv
// gameover_renderer
// Game-over image renderer with a top-down reveal animation, 3-cycle pipeline.
//   clk     : pixel clock
//   reset_n : asynchronous active-low reset
//   bus     : beam inputs, control pulses, ROM port and pixel outputs
module gameover_renderer
  import gameover_pkg::*;
(
  input  logic                clk,
  input  logic                reset_n,
  gameover_renderer_if.slave  bus
);

  localparam logic [1:0] ST_IDLE   = IDLE;
  localparam logic [1:0] ST_REVEAL = REVEAL;
  localparam logic [1:0] ST_HOLD   = HOLD;

  logic [IMG_CW-1:0] iy_s;
  logic              in_img_s;
  logic [ADDR_W-1:0] addr_s;
  logic              vis1_d;

  logic [1:0]        state_q, state_d;
  logic [IMG_CW-1:0] reveal_line_q, reveal_line_d;
  logic [ADDR_W-1:0] rom_addr_q;
  logic              vis1_q, vis2_q;
  logic [IDX_W-1:0]  pix_index_q;
  logic              pix_valid_q;
  logic              reveal_done_q;

  gameover_addr_gen u_addr_gen (
    .draw_x_i (bus.draw_x),
    .draw_y_i (bus.draw_y),
    .de_i     (bus.de),
    .iy_o     (iy_s),
    .in_img_o (in_img_s),
    .addr_o   (addr_s)
  );

  // Row visibility is judged against the reveal line as it stands when the
  // coordinate is sampled; later state changes do not alter in-flight pixels.
  assign vis1_d = in_img_s && (state_q != ST_IDLE) && (iy_s < reveal_line_q);

  // Reveal FSM next state; clear overrides every other event.
  always_comb begin
    state_d       = state_q;
    reveal_line_d = reveal_line_q;
    if (bus.clear) begin
      state_d       = ST_IDLE;
      reveal_line_d = {IMG_CW{1'b0}};
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            state_d       = ST_REVEAL;
            reveal_line_d = {IMG_CW{1'b0}};
          end else begin
            state_d       = ST_IDLE;
          end
        end
        ST_REVEAL: begin
          if (bus.frame_start) begin
            reveal_line_d = next_reveal(reveal_line_q);
            if (next_reveal(reveal_line_q) == IMG_CW'(IMG_H)) begin
              state_d = ST_HOLD;
            end else begin
              state_d = ST_REVEAL;
            end
          end else begin
            state_d = ST_REVEAL;
          end
        end
        ST_HOLD: begin
          state_d       = ST_HOLD;
          reveal_line_d = IMG_CW'(IMG_H);
        end
        default: begin
          state_d       = ST_IDLE;
          reveal_line_d = {IMG_CW{1'b0}};
        end
      endcase
    end
  end

  // State, reveal line and the three pipeline stages.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      reveal_line_q <= {IMG_CW{1'b0}};
      rom_addr_q    <= {ADDR_W{1'b0}};
      vis1_q        <= 1'b0;
      vis2_q        <= 1'b0;
      pix_index_q   <= {IDX_W{1'b0}};
      pix_valid_q   <= 1'b0;
      reveal_done_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      reveal_line_q <= reveal_line_d;
      reveal_done_q <= (state_d == ST_HOLD);
      rom_addr_q    <= addr_s;
      vis1_q        <= vis1_d;
      vis2_q        <= vis1_q;
      pix_index_q   <= vis2_q ? bus.rom_data : {IDX_W{1'b0}};
      pix_valid_q   <= vis2_q;
    end
  end

  assign bus.rom_addr    = rom_addr_q;
  assign bus.pix_index   = pix_index_q;
  assign bus.pix_valid   = pix_valid_q;
  assign bus.reveal_done = reveal_done_q;

endmodule

// File: tb/tb_gameover_renderer.sv
// tb_gameover_renderer
// Randomised plus directed stimulus; a behavioural model pushes expected
// outputs into queues tagged with the cycle they are due, and a monitor on
// the falling edge pops and compares them.
module tb_gameover_renderer;
  import gameover_pkg::*;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  gameover_renderer_if bus ();

  gameover_renderer dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct { int due; int val; } exp_t;
  exp_t q_addr[$];
  exp_t q_idx[$];
  exp_t q_vld[$];
  exp_t q_done[$];

  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;
  int m_mode = 0;   // 0 idle, 1 revealing, 2 holding
  int m_rows = 0;   // number of image rows currently revealed

  always @(posedge clk) cyc <= cyc + 1;

  // Image ROM contents: an arbitrary scramble of the address.
  function automatic logic [3:0] rom_fn(input logic [14:0] a);
    logic [3:0] r;
    r = a[3:0] ^ a[7:4] ^ a[11:8] ^ {1'b0, a[14:12]};
    r = r + a[4:1];
    return r;
  endfunction

  // Synchronous ROM: data one cycle after the address.
  always @(posedge clk) bus.rom_data <= rom_fn(bus.rom_addr);

  task automatic check(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cycle %0d: got %0d, expected %0d", nm, cyc, act, exp);
    end
  endtask

  // Monitor: compare every expectation that falls due this cycle.
  always @(negedge clk) begin : monitor
    exp_t e;
    while (q_addr.size() > 0 && q_addr[0].due <= cyc) begin
      e = q_addr.pop_front();
      check("rom_addr", int'(bus.rom_addr), e.val);
    end
    while (q_done.size() > 0 && q_done[0].due <= cyc) begin
      e = q_done.pop_front();
      check("reveal_done", int'(bus.reveal_done), e.val);
    end
    while (q_vld.size() > 0 && q_vld[0].due <= cyc) begin
      e = q_vld.pop_front();
      check("pix_valid", int'(bus.pix_valid), e.val);
    end
    while (q_idx.size() > 0 && q_idx[0].due <= cyc) begin
      e = q_idx.pop_front();
      check("pix_index", int'(bus.pix_index), e.val);
    end
  end

  // Apply one cycle of inputs, record the expected responses, advance the model.
  task automatic drive(input int x, input int y, input bit d,
                       input bit fs, input bit st, input bit cl);
    int ix, iy, addr;
    bit inimg, vis;
    @(posedge clk);
    #1;
    bus.draw_x      = 10'(x);
    bus.draw_y      = 10'(y);
    bus.de          = d;
    bus.frame_start = fs;
    bus.start       = st;
    bus.clear       = cl;
    ix    = x / 4;
    iy    = y / 4;
    inimg = d && (ix < 160) && (iy < 120);
    addr  = inimg ? (iy * 160 + ix) : 0;
    vis   = inimg && (m_mode != 0) && (iy < m_rows);
    q_addr.push_back('{cyc + 1, addr});
    q_idx.push_back('{cyc + 3, vis ? int'(rom_fn(15'(addr))) : 0});
    q_vld.push_back('{cyc + 3, int'(vis)});
    if (cl) begin
      m_mode = 0; m_rows = 0;
    end else if (m_mode == 0 && st) begin
      m_mode = 1; m_rows = 0;
    end else if (m_mode == 1 && fs) begin
      m_rows = (m_rows + 4 > 120) ? 120 : m_rows + 4;
      if (m_rows == 120) m_mode = 2;
    end
    q_done.push_back('{cyc + 1, int'(m_mode == 2)});
  endtask

  task automatic drive_rand_pix(input int n);
    for (int i = 0; i < n; i++) begin
      drive($urandom_range(0, 660), $urandom_range(0, 500), ($urandom % 8) != 0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic check_zero_outputs(input string nm);
    check({nm, "_rom_addr"}, int'(bus.rom_addr), 0);
    check({nm, "_pix_index"}, int'(bus.pix_index), 0);
    check({nm, "_pix_valid"}, int'(bus.pix_valid), 0);
    check({nm, "_reveal_done"}, int'(bus.reveal_done), 0);
  endtask

  initial begin
    bus.draw_x = 10'd0; bus.draw_y = 10'd0; bus.de = 1'b0;
    bus.frame_start = 1'b0; bus.start = 1'b0; bus.clear = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_zero_outputs("reset");
    reset_n = 1'b1;

    // Idle: nothing drawn whatever the beam or frame pulses do.
    for (int i = 0; i < 150; i++) begin
      drive($urandom_range(0, 799), $urandom_range(0, 524), 1'b1, (i % 15) == 0, 1'b0, 1'b0);
    end

    // start and clear together: clear wins, stays idle.
    drive(40, 40, 1'b1, 1'b0, 1'b1, 1'b1);
    drive_rand_pix(20);

    // start with frame_start in idle: enters reveal without stepping.
    drive(40, 0, 1'b1, 1'b1, 1'b1, 1'b0);
    drive(40, 0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= 30; k++) begin
      drive(200, 200, 1'b1, 1'b1, (k == 10), 1'b0);   // start mid-reveal is ignored
      drive(40, 16 * k - 4, 1'b1, 1'b0, 1'b0, 1'b0);  // last revealed row
      drive(40, 16 * k, 1'b1, 1'b0, 1'b0, 1'b0);      // first hidden row
      drive_rand_pix(4);
    end

    // Hold: address map and window edges.
    drive(8, 4, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(639, 0, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(639, 479, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(100, 480, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(100, 100, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(640, 100, 1'b1, 1'b1, 1'b0, 1'b0);
    drive_rand_pix(20);

    // Clear in hold, then in-image pixels must drain away.
    drive(300, 300, 1'b1, 1'b0, 1'b0, 1'b1);
    drive_rand_pix(8);

    // Randomised run with sparse events.
    for (int i = 0; i < 2500; i++) begin
      drive($urandom_range(0, 799), $urandom_range(0, 524), ($urandom % 8) != 0,
            ($urandom % 16) == 0, ($urandom % 64) == 0, ($urandom % 300) == 0);
    end

    // Async reset mid-reveal, between clock edges.
    drive(0, 0, 1'b1, 1'b0, 1'b0, 1'b1);
    drive(0, 0, 1'b1, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 5; k++) begin
      drive(200, 200, 1'b1, 1'b1, 1'b0, 1'b0);
      drive_rand_pix(3);
    end
    drive(40, 4, 1'b1, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    check_zero_outputs("async_reset");
    q_addr.delete(); q_idx.delete(); q_vld.delete(); q_done.delete();
    m_mode = 0; m_rows = 0;
    bus.start = 1'b0; bus.clear = 1'b0; bus.frame_start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // After release nothing is drawn until a fresh start.
    for (int i = 0; i < 40; i++) begin
      drive($urandom_range(0, 639), $urandom_range(0, 40), 1'b1, (i % 8) == 0, 1'b0, 1'b0);
    end
    drive(0, 0, 1'b1, 1'b0, 1'b1, 1'b0);
    drive(0, 0, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 30; i++) begin
      drive($urandom_range(0, 639), $urandom_range(0, 31), 1'b1, 1'b0, 1'b0, 1'b0);
    end

    // Drain the pipeline and confirm every expectation was consumed.
    for (int i = 0; i < 5; i++) drive(0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    check("drain_pix_queue", q_idx.size() + q_vld.size(), 0);
    check("drain_ctl_queue", q_addr.size() + q_done.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
